// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the MiniCPU sequencer: opcodes, ALU codes and FSM state encoding.
package cpu_ctrl_pkg;

    localparam int PC_W_DEF = 4;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDA   = 4'h1;
    localparam logic [3:0] OP_LDB   = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_SUB   = 4'h6;
    localparam logic [3:0] OP_OR    = 4'h7;
    localparam logic [3:0] OP_STORE = 4'h8;
    localparam logic [3:0] OP_OUT   = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_DECODE   = 3'd2,
        S_EXEC     = 3'd3,
        S_OUT_WAIT = 3'd4,
        S_HALTED   = 3'd5
    } state_t;

endpackage

// File: rtl/cpu_decoder.sv
// Combinational opcode decoder: maps IR[7:4] to the control strobes and the sequencing flags.
module cpu_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       a_we,
    output logic       b_we,
    output logic       alu_we,
    output logic [1:0] alu_op,
    output logic       out_we,
    output logic       is_out,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        a_we       = 1'b0;
        b_we       = 1'b0;
        alu_we     = 1'b0;
        alu_op     = ALU_ADD;
        out_we     = 1'b0;
        is_out     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_NOP:   ;
            OP_LDA:   a_we = 1'b1;
            OP_LDB:   b_we = 1'b1;
            OP_ADD:   begin alu_we = 1'b1; alu_op = ALU_ADD; end
            OP_AND:   begin alu_we = 1'b1; alu_op = ALU_AND; end
            OP_SUB:   begin alu_we = 1'b1; alu_op = ALU_SUB; end
            OP_OR:    begin alu_we = 1'b1; alu_op = ALU_OR;  end
            OP_STORE: out_we = 1'b1;
            OP_OUT:   is_out = 1'b1;
            OP_HALT:  is_halt = 1'b1;
            // Undefined opcodes behave as NOP but are flagged
            default:  is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// MiniCPU sequencer: FETCH/DECODE/EXEC loop driving the ROM address, issuing one-cycle
// datapath strobes and owning run/halt plus the out_valid/out_ready handshake.
module cpu_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter logic [PC_W-1:0] LAST_ADDR = PC_W'(15),
    parameter bit              WRAP      = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      instr,
    input  logic            out_ready,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      imm,
    output logic            a_we,
    output logic            b_we,
    output logic            alu_we,
    output logic [1:0]      alu_op,
    output logic            out_we,
    output logic            out_valid,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);

    state_t          state, state_nxt;
    logic [7:0]      ir_p0;
    logic            a_we_p1, b_we_p1, alu_we_p1, out_we_p1;
    logic [1:0]      alu_op_p1;
    logic            is_out_p1, is_halt_p1, is_illegal_p1;
    logic            dc_a_we, dc_b_we, dc_alu_we, dc_out_we;
    logic [1:0]      dc_alu_op;
    logic            dc_is_out, dc_is_halt, dc_is_illegal;
    logic            illegal_q;
    logic            at_last;
    logic            end_halt;
    logic [PC_W-1:0] pc_adv;

    cpu_decoder u_dec (
        .opcode     (ir_p0[7:4]),
        .a_we       (dc_a_we),
        .b_we       (dc_b_we),
        .alu_we     (dc_alu_we),
        .alu_op     (dc_alu_op),
        .out_we     (dc_out_we),
        .is_out     (dc_is_out),
        .is_halt    (dc_is_halt),
        .is_illegal (dc_is_illegal)
    );

    // Without WRAP the last address parks pc on itself and the FSM halts
    assign at_last  = (pc == LAST_ADDR);
    assign end_halt = at_last && !WRAP;
    assign pc_adv   = at_last ? (WRAP ? '0 : pc) : pc + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_HALTED: if (start) state_nxt = S_FETCH;
            S_FETCH:          state_nxt = S_DECODE;
            S_DECODE:         state_nxt = S_EXEC;
            S_EXEC: begin
                if (is_out_p1)                    state_nxt = S_OUT_WAIT;
                else if (is_halt_p1 || end_halt)  state_nxt = S_HALTED;
                else                              state_nxt = S_FETCH;
            end
            S_OUT_WAIT: if (out_ready) state_nxt = end_halt ? S_HALTED : S_FETCH;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Stage boundary: IR captured in FETCH (p0), decode registered in DECODE (p1)
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= '0;
            ir_p0         <= '0;
            a_we_p1       <= 1'b0;
            b_we_p1       <= 1'b0;
            alu_we_p1     <= 1'b0;
            alu_op_p1     <= '0;
            out_we_p1     <= 1'b0;
            is_out_p1     <= 1'b0;
            is_halt_p1    <= 1'b0;
            is_illegal_p1 <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        pc        <= '0;
                        illegal_q <= 1'b0;
                    end
                end
                S_FETCH: ir_p0 <= instr;
                S_DECODE: begin
                    a_we_p1       <= dc_a_we;
                    b_we_p1       <= dc_b_we;
                    alu_we_p1     <= dc_alu_we;
                    alu_op_p1     <= dc_alu_op;
                    out_we_p1     <= dc_out_we;
                    is_out_p1     <= dc_is_out;
                    is_halt_p1    <= dc_is_halt;
                    is_illegal_p1 <= dc_is_illegal;
                end
                S_EXEC: begin
                    if (is_illegal_p1) illegal_q <= 1'b1;
                    if (!is_out_p1 && !is_halt_p1) pc <= pc_adv;
                end
                S_OUT_WAIT: if (out_ready) pc <= pc_adv;
                default: ;
            endcase
        end
    end

    always_comb begin
        a_we      = (state == S_EXEC) && a_we_p1;
        b_we      = (state == S_EXEC) && b_we_p1;
        alu_we    = (state == S_EXEC) && alu_we_p1;
        alu_op    = alu_we ? alu_op_p1 : 2'b00;
        out_we    = (state == S_EXEC) && out_we_p1;
        out_valid = (state == S_OUT_WAIT);
        busy      = (state == S_FETCH) || (state == S_DECODE) ||
                    (state == S_EXEC)  || (state == S_OUT_WAIT);
        halted    = (state == S_HALTED);
        imm       = ir_p0[3:0];
        illegal   = illegal_q;
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: ROM model, small A/B datapath model and a strobe scoreboard.
module tb_cpu_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, out_ready;
    logic       start1, out_ready1;
    logic [7:0] rom [16];
    logic [7:0] instr, instr1;

    logic [3:0] pc, imm;
    logic       a_we, b_we, alu_we, out_we, out_valid, busy, halted, illegal;
    logic [1:0] alu_op;

    logic [3:0] pc1, imm1;
    logic       a_we1, b_we1, alu_we1, out_we1, out_valid1, busy1, halted1, illegal1;
    logic [1:0] alu_op1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign instr  = rom[pc];
    assign instr1 = rom[pc1];

    cpu_ctrl #(.PC_W(4), .LAST_ADDR(4'd15), .WRAP(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .out_ready(out_ready),
        .pc(pc), .imm(imm), .a_we(a_we), .b_we(b_we), .alu_we(alu_we), .alu_op(alu_op),
        .out_we(out_we), .out_valid(out_valid), .busy(busy), .halted(halted), .illegal(illegal)
    );

    cpu_ctrl #(.PC_W(4), .LAST_ADDR(4'd15), .WRAP(1'b1)) dut_wrap (
        .clk(clk), .rst(rst), .start(start1), .instr(instr1), .out_ready(out_ready1),
        .pc(pc1), .imm(imm1), .a_we(a_we1), .b_we(b_we1), .alu_we(alu_we1), .alu_op(alu_op1),
        .out_we(out_we1), .out_valid(out_valid1), .busy(busy1), .halted(halted1), .illegal(illegal1)
    );

    localparam logic [4:0] K_A   = 5'b10000;
    localparam logic [4:0] K_B   = 5'b01000;
    localparam logic [4:0] K_ALU = 5'b00100;
    localparam logic [4:0] K_ST  = 5'b00010;
    localparam logic [4:0] K_X   = 5'b00001;

    logic [14:0] sbq [$];
    logic [14:0] obs_ev;
    logic [17:0] outs;

    assign obs_ev = {a_we, b_we, alu_we, out_we, out_valid & out_ready, alu_op, imm, pc};
    assign outs   = {pc, imm, a_we, b_we, alu_we, alu_op, out_we, out_valid, busy, halted, illegal};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input logic [4:0] k, input logic [1:0] op, input logic [3:0] im,
                           input logic [3:0] p);
        sbq.push_back({k, op, im, p});
    endtask

    // Every strobe or completed transfer must match the next expected event
    always @(negedge clk) begin
        if (a_we || b_we || alu_we || out_we || (out_valid && out_ready)) begin
            if (sbq.size() == 0) chk("sb_unexpected", {17'd0, obs_ev}, 32'd0);
            else                 chk("sb_event", {17'd0, obs_ev}, {17'd0, sbq.pop_front()});
        end
    end

    // Reference datapath driven by the strobes
    logic [3:0] ra, rb, rout, rport;
    always @(posedge clk) begin
        if (rst) begin
            ra <= 4'd0; rb <= 4'd0; rout <= 4'd0; rport <= 4'd0;
        end else begin
            if (a_we) ra <= imm;
            if (b_we) rb <= imm;
            if (alu_we) begin
                case (alu_op)
                    2'b00: ra <= ra + rb;
                    2'b01: ra <= ra & rb;
                    2'b10: ra <= ra - rb;
                    default: ra <= ra | rb;
                endcase
            end
            if (out_we) rout <= ra;
            if (out_valid && out_ready) rport <= ra;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    task automatic wait_halted(output int n);
        n = 0;
        while (!halted && n < 300) begin
            tick(1);
            n++;
        end
        chk("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; start1 = 1'b0; out_ready1 = 1'b1;
        clear_rom();
        tick(2);
        chk("rst_outs", {14'd0, outs}, 32'd0);
        chk("rst_outs_wrap", {25'd0, pc1, busy1, halted1, illegal1}, 32'd0);
        rst = 1'b0;
        tick(1);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // LDA/LDB/ADD then HALT
        rom[0] = 8'h13; rom[1] = 8'h25; rom[2] = 8'h40; rom[3] = 8'hF0;
        push_ev(K_A, 2'b00, 4'd3, 4'd0);
        push_ev(K_B, 2'b00, 4'd5, 4'd1);
        push_ev(K_ALU, 2'b00, 4'd0, 4'd2);
        pulse_start();
        chk("start_pc", {28'd0, pc}, 32'd0);
        chk("start_busy", {31'd0, busy}, 32'd1);
        tick(1);
        chk("decode_nostrobe", {28'd0, a_we, b_we, alu_we, out_we}, 32'd0);
        tick(1);
        chk("c3_a_we", {31'd0, a_we}, 32'd1);
        chk("c3_imm", {28'd0, imm}, 32'd3);
        tick(1);
        chk("pc_after_lda", {28'd0, pc}, 32'd1);
        chk("a_we_one_cycle", {31'd0, a_we}, 32'd0);
        tick(2);
        chk("c6_b_we", {31'd0, b_we}, 32'd1);
        tick(3);
        chk("c9_alu_we", {31'd0, alu_we}, 32'd1);
        chk("c9_alu_op", {30'd0, alu_op}, 32'd0);
        tick(1);
        chk("add_result", {28'd0, ra}, 32'd8);
        wait_halted(n);
        chk("halt_latency", n, 32'd3);
        chk("halt_pc", {28'd0, pc}, 32'd3);
        chk("halt_busy", {31'd0, busy}, 32'd0);

        // OUT with out_ready low for 4 cycles
        do_reset();
        clear_rom();
        rom[0] = 8'hC0; rom[1] = 8'hF0;
        out_ready = 1'b0;
        push_ev(K_X, 2'b00, 4'd0, 4'd0);
        pulse_start();
        tick(3);
        for (int i = 0; i < 4; i++) begin
            chk("ow_valid", {31'd0, out_valid}, 32'd1);
            chk("ow_pc_stall", {28'd0, pc}, 32'd0);
            tick(1);
        end
        out_ready = 1'b1;
        chk("ow_valid5", {31'd0, out_valid}, 32'd1);
        tick(1);
        out_ready = 1'b0;
        chk("ow_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("ow_pc_adv", {28'd0, pc}, 32'd1);
        wait_halted(n);

        // OUT with out_ready already high
        do_reset();
        out_ready = 1'b1;
        push_ev(K_X, 2'b00, 4'd0, 4'd0);
        pulse_start();
        tick(2);
        chk("ox_exec_novalid", {31'd0, out_valid}, 32'd0);
        tick(1);
        chk("ox_valid", {31'd0, out_valid}, 32'd1);
        tick(1);
        chk("ox_valid_1cyc", {31'd0, out_valid}, 32'd0);
        chk("ox_pc", {28'd0, pc}, 32'd1);
        wait_halted(n);

        // 12-instruction demo program, NOPs to the end, no wrap
        do_reset();
        clear_rom();
        rom[0] = 8'h13; rom[1] = 8'h25; rom[2]  = 8'h40; rom[3]  = 8'h80;
        rom[4] = 8'h21; rom[5] = 8'h60; rom[6]  = 8'h2C; rom[7]  = 8'h50;
        rom[8] = 8'h23; rom[9] = 8'h70; rom[10] = 8'hC0; rom[11] = 8'h80;
        push_ev(K_A, 2'b00, 4'd3, 4'd0);
        push_ev(K_B, 2'b00, 4'd5, 4'd1);
        push_ev(K_ALU, 2'b00, 4'd0, 4'd2);
        push_ev(K_ST, 2'b00, 4'd0, 4'd3);
        push_ev(K_B, 2'b00, 4'd1, 4'd4);
        push_ev(K_ALU, 2'b10, 4'd0, 4'd5);
        push_ev(K_B, 2'b00, 4'hC, 4'd6);
        push_ev(K_ALU, 2'b01, 4'd0, 4'd7);
        push_ev(K_B, 2'b00, 4'd3, 4'd8);
        push_ev(K_ALU, 2'b11, 4'd0, 4'd9);
        push_ev(K_X, 2'b00, 4'd0, 4'd10);
        push_ev(K_ST, 2'b00, 4'd0, 4'd11);
        out_ready = 1'b1;
        pulse_start();
        wait_halted(n);
        chk("demo_cycles", n, 32'd49);
        chk("demo_pc", {28'd0, pc}, 32'd15);
        chk("demo_a", {28'd0, ra}, 32'd7);
        chk("demo_store", {28'd0, rout}, 32'd7);
        chk("demo_port", {28'd0, rport}, 32'd7);
        chk("demo_illegal", {31'd0, illegal}, 32'd0);
        pulse_start();
        chk("restart_pc", {28'd0, pc}, 32'd0);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        chk("restart_halted", {31'd0, halted}, 32'd0);
        tick(1);
        do_reset();

        // Same program on the wrapping instance
        start1 = 1'b1;
        tick(1);
        start1 = 1'b0;
        tick(49);
        chk("wrap_pc0", {28'd0, pc1}, 32'd0);
        chk("wrap_busy", {31'd0, busy1}, 32'd1);
        chk("wrap_not_halted", {31'd0, halted1}, 32'd0);
        tick(3);
        chk("wrap_pc1", {28'd0, pc1}, 32'd1);
        do_reset();

        // Illegal opcode then HALT
        clear_rom();
        rom[0] = 8'h93; rom[1] = 8'h13; rom[2] = 8'hF0; rom[3] = 8'h25;
        push_ev(K_A, 2'b00, 4'd3, 4'd1);
        pulse_start();
        tick(2);
        chk("ill_nostrobe", {28'd0, a_we, b_we, alu_we, out_we}, 32'd0);
        tick(1);
        chk("ill_set", {31'd0, illegal}, 32'd1);
        chk("ill_pc", {28'd0, pc}, 32'd1);
        wait_halted(n);
        chk("hlt_latency", n, 32'd6);
        chk("hlt_pc", {28'd0, pc}, 32'd2);
        chk("ill_sticky", {31'd0, illegal}, 32'd1);
        tick(3);
        chk("hlt_pc_held", {28'd0, pc}, 32'd2);
        chk("hlt_stays", {31'd0, halted}, 32'd1);
        pulse_start();
        chk("ill_cleared", {31'd0, illegal}, 32'd0);
        chk("hlt_restart_pc", {28'd0, pc}, 32'd0);
        chk("hlt_restart_busy", {31'd0, busy}, 32'd1);
        do_reset();

        // Reset during OUT_WAIT, with start held during reset
        clear_rom();
        rom[0] = 8'hC0;
        out_ready = 1'b0;
        pulse_start();
        tick(3);
        chk("mid_ow_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1; start = 1'b1;
        tick(1);
        chk("mid_ow_rst_outs", {14'd0, outs}, 32'd0);
        tick(1);
        chk("mid_rst_start_ign", {14'd0, outs}, 32'd0);
        rst = 1'b0; start = 1'b0;
        tick(1);
        chk("mid_idle", {31'd0, busy}, 32'd0);

        // Reset during EXEC
        rom[0] = 8'h13;
        push_ev(K_A, 2'b00, 4'd3, 4'd0);
        pulse_start();
        tick(2);
        chk("mid_exec_a_we", {31'd0, a_we}, 32'd1);
        rst = 1'b1;
        tick(1);
        chk("mid_exec_rst_outs", {14'd0, outs}, 32'd0);
        rst = 1'b0;
        tick(1);
        chk("mid_exec_idle", {31'd0, busy}, 32'd0);

        chk("sb_left", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
